// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-side branch predictor: counter encodings and PC field helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package bp_pkg;

  // Two-bit direction counter encodings
  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not-taken
    WNT = 2'b01,  // weakly not-taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } bp_ctr_e;

  // Every counter comes out of reset weakly not-taken
  localparam logic [1:0] BP_CTR_RST = WNT;

  // Default geometry: 64 entries, index pc[7:2], tag pc[31:8]
  localparam int BP_ENTRIES = 64;
  localparam int BP_IDX_W   = 6;
  localparam int BP_TAG_W   = 30 - BP_IDX_W;

  // Sequential fetch step
  localparam logic [31:0] BP_PC_STEP = 32'd4;

  // Table index of a PC, returned right-aligned in a 32-bit word (pc[1:0] dropped).
  function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w = BP_IDX_W);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  // Tag of a PC: every bit above the index, right-aligned in a 32-bit word.
  function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_w = BP_IDX_W);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one 2-bit saturating direction counter (increment, decrement or load WT).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is written back.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_load_wt,
  output logic [1:0] o_ctr
);

  // Load has priority (a new BTB owner restarts at weakly taken); otherwise saturate at the ends.
  always_comb begin
    o_ctr = i_ctr;
    if (i_load_wt) begin
      o_ctr = WT;
    end else if (i_inc) begin
      if (i_ctr != ST) begin
        o_ctr = i_ctr + 2'd1;
      end
    end else if (i_dec) begin
      if (i_ctr != SNT) begin
        o_ctr = i_ctr - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: 2-bit counter BHT plus tagged direct-mapped BTB, trained by ID/EX.
// Latency: lookup and mispredict are combinational; updates become visible the cycle after the edge.
// Backpressure: none; one lookup and at most one update per cycle. Optional BP_STATS_EN adds counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int IDX_W   = BP_IDX_W,
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  // ------------------------------------------------------------------
  // Table storage (flops, every entry cleared by the async reset)
  // ------------------------------------------------------------------
  logic [1:0]       r_ctr [ENTRIES];
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [ENTRIES];
  logic [31:0]      r_tgt [ENTRIES];

  // ------------------------------------------------------------------
  // PC field extraction
  // ------------------------------------------------------------------
  logic [31:0]      w_lk_idx_full;
  logic [31:0]      w_lk_tag_full;
  logic [31:0]      w_up_idx_full;
  logic [31:0]      w_up_tag_full;
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;

  assign w_lk_idx_full = bp_idx(if_pc, IDX_W);
  assign w_lk_tag_full = bp_tag(if_pc, IDX_W);
  assign w_up_idx_full = bp_idx(upd_pc, IDX_W);
  assign w_up_tag_full = bp_tag(upd_pc, IDX_W);

  assign w_lk_idx = w_lk_idx_full[IDX_W-1:0];
  assign w_lk_tag = w_lk_tag_full[TAG_W-1:0];
  assign w_up_idx = w_up_idx_full[IDX_W-1:0];
  assign w_up_tag = w_up_tag_full[TAG_W-1:0];

  // The helpers return zero-extended words; only the low field bits matter here.
  logic w_unused_bits;
  assign w_unused_bits = ^{w_lk_idx_full[31:IDX_W], w_lk_tag_full[31:TAG_W],
                           w_up_idx_full[31:IDX_W], w_up_tag_full[31:TAG_W]};

  // ------------------------------------------------------------------
  // Lookup: reads the registered tables only, so a same-cycle update is not bypassed
  // ------------------------------------------------------------------
  logic        w_lk_hit;
  logic        w_lk_taken;
  logic [31:0] w_pc_next;

  assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign w_pc_next   = if_pc + BP_PC_STEP;   // wraps naturally modulo 2^32

  assign pred_hit    = w_lk_hit;
  assign pred_taken  = w_lk_taken;
  assign pred_target = w_lk_taken ? r_tgt[w_lk_idx] : w_pc_next;

  // ------------------------------------------------------------------
  // Update path
  // ------------------------------------------------------------------
  logic       w_up_hit;
  logic       w_ctr_inc;
  logic       w_ctr_dec;
  logic       w_ctr_load;
  logic [1:0] w_ctr_nxt;

  // A taken branch that does not own the BTB entry takes it over and restarts at WT.
  // A not-taken branch always decrements, even if the entry belongs to another PC.
  assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_ctr_inc  = upd_taken && w_up_hit;
  assign w_ctr_load = upd_taken && !w_up_hit;
  assign w_ctr_dec  = !upd_taken;

  bp_sat_counter u_sat_counter (
    .i_ctr     (r_ctr[w_up_idx]),
    .i_inc     (w_ctr_inc),
    .i_dec     (w_ctr_dec),
    .i_load_wt (w_ctr_load),
    .o_ctr     (w_ctr_nxt)
  );

  // Table write: clear everything on reset, otherwise retire one resolved branch per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i]   <= BP_CTR_RST;
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
      end
    end else if (upd_valid) begin
      r_ctr[w_up_idx] <= w_ctr_nxt;
      if (upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_tag[w_up_idx]   <= w_up_tag;
        r_tgt[w_up_idx]   <= upd_target;
      end
    end
  end

  // ------------------------------------------------------------------
  // Mispredict: wrong direction, or right "taken" direction with a wrong target.
  // Held low while reset is asserted so the front end sees no redirect.
  // ------------------------------------------------------------------
  logic w_mp_cond;

  assign w_mp_cond  = (upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_target != upd_pred_target));
  assign mispredict = reset && upd_valid && w_mp_cond;

`ifdef BP_STATS_EN
  // ------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // ------------------------------------------------------------------
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  // Count every resolved branch and every redirect it caused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (upd_valid) begin
        r_stat_br <= r_stat_br + 32'd1;
      end
      if (mispredict) begin
        r_stat_mp <= r_stat_mp + 32'd1;
      end
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (64 entries): scoreboard of expected lookup/mispredict results.
// Latency: expectations pushed when a cycle is driven, popped and compared 2 time units later.
// Backpressure: none; build with BP_STATS_EN defined to also check the statistics counters.
module tb_branch_predictor;

  localparam logic [31:0] PC_A  = 32'h0040_0010;
  localparam logic [31:0] PC_B  = 32'h0040_0110;  // same index as PC_A, different tag
  localparam logic [31:0] PC_C  = 32'h0040_0020;
  localparam logic [31:0] TGT_A = 32'h0040_0040;
  localparam logic [31:0] TGT_B = 32'h0040_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .IDX_W(6), .TAG_W(24)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_hit        (pred_hit),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic        mp;
  } exp_t;

  exp_t sb[$];

  // Reference model of the tables (64 entries, index pc[7:2], tag pc[31:8])
  logic [1:0]  m_ctr [64];
  logic        m_val [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_br;
  int          m_mp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 2'b01;
      m_val[i] = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  // One cycle: drive at negedge, check 2 units later, hold across the posedge, then drop upd_valid.
  task automatic cyc(input string nm, input logic [31:0] pc,
                     input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                     input logic upt, input logic [31:0] uptgt);
    exp_t e;
    exp_t g;
    int   li;
    int   ui;
    logic uhit;
    @(negedge clk);
    if_pc           = pc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_taken       = ut;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
    li      = int'(pc[7:2]);
    e.hit   = m_val[li] && (m_tag[li] == pc[31:8]);
    e.taken = e.hit && m_ctr[li][1];
    e.tgt   = e.taken ? m_tgt[li] : pc + 32'd4;
    e.mp    = uv && ((ut != upt) || (ut && (utgt != uptgt)));
    sb.push_back(e);
    #2;
    g = sb.pop_front();
    chk({nm, ".hit"},   {31'd0, pred_hit},   {31'd0, g.hit});
    chk({nm, ".taken"}, {31'd0, pred_taken}, {31'd0, g.taken});
    chk({nm, ".tgt"},   pred_target,         g.tgt);
    chk({nm, ".mp"},    {31'd0, mispredict}, {31'd0, g.mp});
    if (uv) begin
      m_br++;
      if (g.mp) m_mp++;
      ui   = int'(upc[7:2]);
      uhit = m_val[ui] && (m_tag[ui] == upc[31:8]);
      if (ut) begin
        if (!uhit)                 m_ctr[ui] = 2'b10;
        else if (m_ctr[ui] != 2'b11) m_ctr[ui] = m_ctr[ui] + 2'd1;
        m_val[ui] = 1'b1;
        m_tag[ui] = upc[31:8];
        m_tgt[ui] = utgt;
      end else if (m_ctr[ui] != 2'b00) begin
        m_ctr[ui] = m_ctr[ui] - 2'd1;
      end
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] pc);
    cyc(nm, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic train(input string nm, input logic [31:0] pc, input logic ut, input logic [31:0] tgt);
    cyc(nm, pc, 1'b1, pc, ut, tgt, ut, tgt);
  endtask

  // Assert reset with a taken update pending across the next edge; that update must be discarded.
  task automatic do_reset(input string nm);
    @(negedge clk);
    if_pc           = PC_A;
    upd_valid       = 1'b1;
    upd_pc          = PC_C;
    upd_taken       = 1'b1;
    upd_target      = 32'h0040_0080;
    upd_pred_taken  = 1'b0;
    upd_pred_target = PC_C + 32'd4;
    reset           = 1'b0;
    #1;
    chk({nm, ".mp"},    {31'd0, mispredict}, 32'd0);
    chk({nm, ".hit"},   {31'd0, pred_hit},   32'd0);
    chk({nm, ".taken"}, {31'd0, pred_taken}, 32'd0);
    chk({nm, ".tgt"},   pred_target,         32'h0040_0014);
    m_clear();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    if_pc           = PC_A;
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
    m_clear();
    do_reset("rst0");

    // Cold lookup
    look("t1", PC_A);
    chk("t1.tgt_abs", pred_target, 32'h0040_0014);

    // First taken update installs the entry at WT; predicted not-taken so it redirects
    cyc("t2u", PC_A, 1'b1, PC_A, 1'b1, TGT_A, 1'b0, PC_A + 32'd4);
    look("t2", PC_A);
    chk("t2.taken_abs", {31'd0, pred_taken}, 32'd1);
    chk("t2.tgt_abs",   pred_target,         TGT_A);

    // Saturate at ST, then two not-taken: ST->WT keeps taken, WT->WNT stops predicting taken
    for (int i = 0; i < 3; i++) train("t3t", PC_A, 1'b1, TGT_A);
    cyc("t3n1", PC_A, 1'b1, PC_A, 1'b0, 32'd0, 1'b1, TGT_A);
    look("t3l1", PC_A);
    chk("t3l1.taken_abs", {31'd0, pred_taken}, 32'd1);
    cyc("t3n2", PC_A, 1'b1, PC_A, 1'b0, 32'd0, 1'b1, TGT_A);
    look("t3l2", PC_A);
    chk("t3l2.taken_abs", {31'd0, pred_taken}, 32'd0);
    chk("t3l2.hit_abs",   {31'd0, pred_hit},   32'd1);

    // Low PC bits do not affect index or tag
    look("lsb", PC_A | 32'h3);

    // Aliasing: retrain A to ST, B misses, then B takes over at WT (one not-taken drops it to WNT)
    train("t4t", PC_A, 1'b1, TGT_A);
    train("t4t", PC_A, 1'b1, TGT_A);
    look("t4l", PC_B);
    chk("t4l.tgt_abs", pred_target, 32'h0040_0114);
    cyc("t4u", PC_B, 1'b1, PC_B, 1'b1, TGT_B, 1'b0, PC_B + 32'd4);
    look("t4b", PC_B);
    chk("t4b.tgt_abs", pred_target, TGT_B);
    look("t4a", PC_A);
    cyc("t4n", PC_B, 1'b1, PC_B, 1'b0, 32'd0, 1'b1, TGT_B);
    look("t4c", PC_B);
    chk("t4c.taken_abs", {31'd0, pred_taken}, 32'd0);

    // Not-taken from a different tag still decrements but leaves B's BTB entry in place
    cyc("alias_n", PC_B, 1'b1, PC_A, 1'b0, 32'd0, 1'b0, PC_A + 32'd4);
    train("alias_t", PC_B, 1'b1, TGT_B);
    look("alias_l", PC_B);
    chk("alias_l.taken_abs", {31'd0, pred_taken}, 32'd0);

    // PC+4 wraps
    look("wrap", 32'hFFFF_FFFC);
    chk("wrap.tgt_abs", pred_target, 32'h0000_0000);

    // Mispredict detection from a fresh reset
    do_reset("rst1");
    cyc("t5a", PC_A, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 1'b0, 32'h0000_1004);
    cyc("t5b", PC_A, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_4000, 1'b1, 32'h0000_4444);
    cyc("t5c", PC_A, 1'b1, 32'h0000_5000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_5004);
`ifdef BP_STATS_EN
    chk("t5.stat_br", stat_branches,    32'd3);
    chk("t5.stat_mp", stat_mispredicts, 32'd2);
    chk("t5.stat_br_model", stat_branches,    32'(m_br));
    chk("t5.stat_mp_model", stat_mispredicts, 32'(m_mp));
`endif

    // Same-cycle lookup and update of one index sees the old contents
    cyc("t6", PC_A, 1'b1, PC_A, 1'b1, TGT_A, 1'b0, PC_A + 32'd4);
    chk("t6.hit_abs", {31'd0, pred_hit}, 32'd1);
    look("t6b", PC_A);

    // Mid-stream reset clears the tables and drops the coinciding update to PC_C
    do_reset("rst2");
    look("t6c", PC_A);
    chk("t6c.hit_abs", {31'd0, pred_hit}, 32'd0);
    look("t6d", PC_C);
    chk("t6d.tgt_abs", pred_target, PC_C + 32'd4);
`ifdef BP_STATS_EN
    chk("t6.stat_br_clr", stat_branches, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
